// File: rtl/uart_rx_if.sv
// Receive-side result bus of uart_rx: received byte, valid/frame-error strobes, busy.
interface uart_rx_if;
    logic [7:0] out_DataByte;
    logic       out_fValid;
    logic       out_fFrameErr;
    logic       out_fBusy;

    modport master (output out_DataByte, output out_fValid, output out_fFrameErr, output out_fBusy);
    modport slave  (input  out_DataByte, input  out_fValid, input  out_fFrameErr, input  out_fBusy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling at KBAUD clocks per bit.
// Define UART_RX_PARITY_EN for 8E1 framing (parity error reported as a frame error).
module uart_rx #(
    parameter int unsigned KBAUD       = 10416,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_DataBit,
    uart_rx_if.master rx
);
    localparam int unsigned CW = $clog2(KBAUD);
    localparam logic [CW-1:0] HALF = CW'(KBAUD / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(KBAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   line;
    logic                   half_hit, full_hit;
    logic                   good_stop;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in_DataBit};
    assign line     = sync_q[SYNC_STAGES-1];
    assign half_hit = (baud_q == HALF);
    assign full_hit = (baud_q == FULL);

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign good_stop = line & ~perr_q;
`else
    assign good_stop = line;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!line) state_d = S_START;
            S_START: if (half_hit) state_d = line ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (full_hit && bit_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (full_hit) state_d = S_STOP;
`else
            S_DATA:   if (full_hit && bit_q == 3'd7) state_d = S_STOP;
`endif
            // A low stop bit may be a break; hold off until the line returns high.
            S_STOP:  if (full_hit) state_d = line ? S_IDLE : S_WAIT;
            S_WAIT:  if (line) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            S_START: begin
                if (half_hit) begin
                    baud_d = '0;
                    bit_d  = '0;
`ifdef UART_RX_PARITY_EN
                    perr_d = 1'b0;
`endif
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (full_hit) begin
                    shift_d = {line, shift_q[7:1]};
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (full_hit) begin
                    perr_d = ^{shift_q, line};
                    baud_d = '0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (full_hit) begin
                    baud_d = '0;
                    if (good_stop) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: baud_d = '0;
        endcase
    end

    assign rx.out_DataByte  = data_q;
    assign rx.out_fValid    = valid_q;
    assign rx.out_fFrameErr = ferr_q;
    assign rx.out_fBusy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at KBAUD=16; frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int KB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + KB / 2 + 9 * KB + 1 + PB * KB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ferr_cnt = 0;
    int   both_cnt = 0;
    int   vq[$];
    int   vt[$];

    uart_rx_if rx();
    uart_rx #(.KBAUD(KB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_DataBit(line), .rx(rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx.out_fValid) begin
                vq.push_back(int'(rx.out_DataByte));
                vt.push_back(cyc);
            end
            if (rx.out_fFrameErr) ferr_cnt <= ferr_cnt + 1;
            if (rx.out_fValid && rx.out_fFrameErr) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int popv();
        if (vq.size() == 0) return -1;
        void'(vt.pop_front());
        return vq.pop_front();
    endfunction

    task automatic bit_out(input logic b);
        line = b;
        repeat (KB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic pflip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (PB != 0) bit_out(^d ^ pflip);
        bit_out(stop);
        line = 1'b1;
    endtask

    initial begin
        int t0;
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_byte", int'(rx.out_DataByte), 0);
        chk("rst_valid", int'(rx.out_fValid), 0);
        chk("rst_ferr", int'(rx.out_fFrameErr), 0);
        chk("rst_busy", int'(rx.out_fBusy), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single byte, latency from line fall to valid strobe
        t0 = cyc;
        send(8'h46, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t1_count", vq.size(), 1);
        lat = (vt.size() > 0) ? vt[0] - t0 : -100;
        chk("t1_latency", int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        chk("t1_byte", popv(), 'h46);
        chk("t1_ferr", ferr_cnt, 0);

        // back-to-back frames with no idle gap
        send(8'h46, 1'b1, 1'b0);
        send(8'h49, 1'b1, 1'b0);
        send(8'h0A, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_count", vq.size(), 3);
        chk("t2_b0", popv(), 'h46);
        chk("t2_b1", popv(), 'h49);
        chk("t2_b2", popv(), 'h0A);

        // 5-clock glitch must be rejected
        line = 1'b0;
        repeat (5) @(negedge clk);
        line = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_busy", int'(rx.out_fBusy), 0);
        chk("t3_pulses", vq.size() + ferr_cnt, 0);
        send(8'h55, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t3_byte", popv(), 'h55);

        // low stop bit followed by a long break
        send(8'hA5, 1'b0, 1'b0);
        line = 1'b0;
        repeat (40 * KB) @(negedge clk);
        chk("t4_ferr", ferr_cnt, 1);
        chk("t4_novalid", vq.size(), 0);
        chk("t4_hold", int'(rx.out_DataByte), 'h55);
        chk("t4_wait_busy", int'(rx.out_fBusy), 1);
        line = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_idle", int'(rx.out_fBusy), 0);
        send(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_byte", popv(), 'h3C);

        // reset in the middle of data bit 4 of 0xFF
        bit_out(1'b0);
        line = 1'b1;
        repeat (4 * KB + KB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_byte", int'(rx.out_DataByte), 0);
        chk("t5_rst_busy", int'(rx.out_fBusy), 0);
        chk("t5_rst_valid", int'(rx.out_fValid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("t5_nopulse", vq.size() + ferr_cnt, 1);
        send(8'h81, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_byte", popv(), 'h81);

`ifdef UART_RX_PARITY_EN
        send(8'h46, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_good", popv(), 'h46);
        send(8'h46, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_perr", ferr_cnt, 2);
        chk("t6_novalid", vq.size(), 0);
`endif

        chk("never_both", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, LSB first, idle-high line. It is the receive-side counterpart of UartTx and uses the same KBAUD clocks-per-bit convention, so a UartTx output can be looped straight into this input. It oversamples the asynchronous line on the system clock and samples each bit at mid-bit. Each received byte is presented with a one-cycle valid strobe; there is no backpressure. Sits between the board Rx pin and the CPU/peripheral data bus.

Parameters:
KBAUD, 10416, clock cycles per bit (100 MHz / 9600 baud); legal range 4..65535
SYNC_STAGES, 2, synchronizer flops on in_DataBit; legal range 2..3

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_DataBit  input  1  serial line, asynchronous to clk, idle high
out_DataByte  output  8  last correctly framed byte; held until the next good byte
out_fValid  output  1  one-cycle pulse: out_DataByte updated this cycle
out_fFrameErr  output  1  one-cycle pulse: stop bit sampled low
out_fBusy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility): synchronizer flops = 1, state = IDLE, counters = 0, out_DataByte = 0x00, out_fValid = 0, out_fFrameErr = 0, out_fBusy = 0.
- Baud counter width is ceil(log2(KBAUD)). Bit counter is 3 bits.
- IDLE: if the synchronized line is 0, clear the baud counter and go to START.
- START: when the counter reaches KBAUD/2-1 (integer division), sample the line.
  - Sample 1: glitch. Return to IDLE; no output pulse.
  - Sample 0: clear the counter and the bit counter, then go to DATA.
- DATA: when the counter reaches KBAUD-1, sample the line.
  - Shift the sample in at bit 7 and shift right, so the first received bit ends in bit 0.
  - Clear the counter and increment the bit counter.
  - After the 8th sample (bit counter wraps 7->0), go to STOP.
- STOP: when the counter reaches KBAUD-1, sample the line.
  - Sample 1: out_DataByte <= shift register, out_fValid = 1 for one cycle, go to IDLE.
  - Sample 0: out_fFrameErr = 1 for one cycle, out_DataByte unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE. This prevents a held-low break from re-triggering reception.
- Latency: out_fValid asserts SYNC_STAGES + KBAUD/2 + 9*KBAUD + 1 clocks (±1) after the line falling edge, i.e. mid stop bit.
- Back-to-back frames: a new start bit immediately after the stop bit must be received. IDLE is re-entered at mid stop bit, so up to half a bit of line-rate skew is tolerated.
- out_fValid and out_fFrameErr are never high in the same cycle. Both are registered outputs.
- Reset mid-frame: the partial byte is discarded, with no pulse on any output.
- Line held low through reset release: the block receives 0x00, flags a frame error, then waits in WAIT_IDLE. This is the defined behaviour.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples the 9th bit at mid-bit.
  - Error condition: XOR of the 8 data bits and the parity bit = 1.
  - On error, a parity-error flag is latched. At the stop bit it produces an out_fFrameErr pulse instead of out_fValid, and out_DataByte is not updated.
  - Latency increases by KBAUD.
- Undefined: 8N1 as described above. The PARITY state and its logic are absent.

Test Plan:
1. KBAUD=16, UartTx sends 0x46 -> exactly one out_fValid pulse, out_DataByte=0x46, out_fFrameErr stays 0, pulse at latency within ±1 clk.
2. Back-to-back 0x46, 0x49, 0x0A with no idle gap (UartTx restarted on out_fComplete) -> three out_fValid pulses in order with values 0x46, 0x49, 0x0A.
3. Line low for 5 clks, then high (KBAUD=16) -> glitch rejected; no pulses, out_fBusy back to 0 by clk ~10, next byte 0x55 received correctly.
4. Frame 0xA5 with stop bit forced 0, line held low 40 bit times -> one out_fFrameErr pulse, out_DataByte keeps its previous value, no re-trigger until line high, then 0x3C received correctly.
5. rst_n pulsed low during data bit 4 of 0xFF -> outputs return to reset values asynchronously; no pulse for the aborted frame; the next full frame 0x81 is received correctly.
6. UART_RX_PARITY_EN defined: 0x46 with even-parity bit 1 -> valid; same byte with parity bit 0 -> out_fFrameErr pulse and no out_fValid.
